// File: rtl/csa_acc_pkg.sv
// rtl/csa_acc_pkg.sv - shared state encoding and saturating counter helper for csa_accum_seq
package csa_acc_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ACC     = 3'd1;
  localparam logic [2:0] ST_RESOLVE = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_RES_LO  = 3'd4;
  localparam logic [2:0] ST_RES_HI  = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    ACC     = ST_ACC,
    RESOLVE = ST_RESOLVE,
    DONE    = ST_DONE,
    RES_LO  = ST_RES_LO,
    RES_HI  = ST_RES_HI
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] cnt_max);
    return (cnt >= cnt_max) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/csa_accum_seq_csa.sv
// rtl/csa_accum_seq_csa.sv - 3:2 carry-save compressor, bitwise full adders with no carry chain
module csa_accum_seq_csa #(
  parameter int len = 256
) (
  input  logic [len-1:0] a,
  input  logic [len-1:0] b,
  input  logic [len-1:0] c,
  output logic [len-1:0] sum,
  output logic [len-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accum_seq.sv
// rtl/csa_accum_seq.sv - multi-operand carry-save accumulator with final carry-propagate resolve
// Optional build macro CSA_ACC_SPLIT_CPA_EN splits the final add into two half-width cycles.
module csa_accum_seq
  import csa_acc_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [WIDTH-1:0] op_data_i,
  input  logic             op_last_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_data_o,
  output logic [CNT_W-1:0] res_cnt_o,
  output logic             busy_o
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

`ifdef CSA_ACC_SPLIT_CPA_EN
  localparam int HALF = WIDTH / 2;
  localparam int HI_W = WIDTH - HALF;
  localparam state_t RES_FIRST = RES_LO;
  logic half_carry;
`else
  localparam state_t RES_FIRST = RESOLVE;
`endif

  state_t           state, next_state;
  logic [WIDTH-1:0] ps, cs;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] csa_sum, csa_carry, cs_shift;
  logic             beat;

  csa_accum_seq_csa #(.len(WIDTH)) u_csa (
    .a     (ps),
    .b     (cs),
    .c     (op_data_i),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // Carry vector moves up one weight; the bit leaving the top is dropped (mod 2^WIDTH).
  assign cs_shift = WIDTH'({csa_carry, 1'b0});
  assign beat     = op_valid_i & op_ready_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (beat) next_state = op_last_i ? RES_FIRST : ACC;
      ACC:     if (beat && op_last_i) next_state = RES_FIRST;
`ifdef CSA_ACC_SPLIT_CPA_EN
      RES_LO:  next_state = RES_HI;
      RES_HI:  next_state = DONE;
`else
      RESOLVE: next_state = DONE;
`endif
      DONE:    if (res_ready_i) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    op_ready_o = (state == IDLE) || (state == ACC);
    busy_o     = (state != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ps          <= '0;
      cs          <= '0;
      cnt         <= '0;
      res_data_o  <= '0;
      res_cnt_o   <= '0;
      res_valid_o <= 1'b0;
`ifdef CSA_ACC_SPLIT_CPA_EN
      half_carry  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            ps  <= op_data_i;
            cs  <= '0;
            cnt <= CNT_W'(1);
          end
        end
        ACC: begin
          if (beat) begin
            ps  <= csa_sum;
            cs  <= cs_shift;
            cnt <= CNT_W'(sat_inc(32'(cnt), CNT_MAX));
          end
        end
`ifdef CSA_ACC_SPLIT_CPA_EN
        RES_LO: begin
          {half_carry, res_data_o[HALF-1:0]} <= {1'b0, ps[HALF-1:0]} + {1'b0, cs[HALF-1:0]};
        end
        RES_HI: begin
          res_data_o[WIDTH-1:HALF] <= ps[WIDTH-1:HALF] + cs[WIDTH-1:HALF] + HI_W'(half_carry);
          res_cnt_o   <= cnt;
          res_valid_o <= 1'b1;
        end
`else
        RESOLVE: begin
          res_data_o  <= ps + cs;
          res_cnt_o   <= cnt;
          res_valid_o <= 1'b1;
        end
`endif
        DONE: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            ps          <= '0;
            cs          <= '0;
            cnt         <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
